// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsu_if
// Brief   : CPU request/response and word-memory port bundle for mem_lsu.
// Revision: 1.0 - initial release
// ============================================================================
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wstrobe;
    logic        mem_rstrobe;
    logic [31:0] mem_rdata;
    logic        mem_done;

    // LSU side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_done,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_wmask, mem_wstrobe, mem_rstrobe
    );

    // CPU plus memory side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_done,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_wmask, mem_wstrobe, mem_rstrobe
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsu
// Brief   : RV32 load/store unit onto a word-addressed strobe/done memory port.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    mem_lsu_if.slave   bus
);
    localparam int             CW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_rdata;
    logic [1:0]  r_err;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wmask;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misal;
    logic [1:0]  w_dec_err;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

    // funct3[1:0] encodes access size; funct3[2] (unsigned) is load-only
    assign w_illegal = (bus.req_funct3[1:0] == 2'b11) ||
                       (bus.req_funct3[2] && (bus.req_we || bus.req_funct3[1]));
    assign w_misal   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign w_dec_err = w_illegal ? 2'b11 : (w_misal ? 2'b01 : 2'b00);

    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = 32'd0;
        if (bus.req_we) begin
            case (bus.req_funct3[1:0])
                2'b00: begin
                    w_mask  = 4'b0001 << bus.req_addr[1:0];
                    w_wdata = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    w_mask  = 4'b0011 << bus.req_addr[1:0];
                    w_wdata = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    w_mask  = 4'b1111;
                    w_wdata = bus.req_wdata;
                end
            endcase
        end
    end

    // Alignment is already guaranteed, so lane selection is a plain part-select
    assign w_byte = bus.mem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = bus.mem_rdata[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        case (r_f3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid)
                         w_state_next = (w_dec_err != 2'b00) ? S_RESP : S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (bus.mem_done || (r_cnt == C_CNT_LAST))
                         w_state_next = S_RESP;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_f3        <= 3'd0;
            r_off       <= 2'd0;
            r_cnt       <= '0;
            r_rdata     <= 32'd0;
            r_err       <= 2'b00;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wmask <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_we    <= bus.req_we;
                    r_f3    <= bus.req_funct3;
                    r_off   <= bus.req_addr[1:0];
                    r_err   <= w_dec_err;
                    r_rdata <= 32'd0;
                    // Bus-facing registers only move for requests that will be issued
                    if (w_dec_err == 2'b00) begin
                        r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        r_mem_wdata <= w_wdata;
                        r_mem_wmask <= w_mask;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (bus.mem_done) begin
                        if (!r_we) r_rdata <= w_load_data;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_err <= 2'b10;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE);
    assign bus.resp_valid  = (r_state == S_RESP);
    assign bus.resp_rdata  = r_rdata;
    assign bus.resp_err    = r_err;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_wmask   = r_mem_wmask;
    assign bus.mem_wstrobe = (r_state == S_ISSUE) && r_we;
    assign bus.mem_rstrobe = (r_state == S_ISSUE) && !r_we;
endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_lsu
// Brief   : Directed plus randomized bench for mem_lsu against a byte-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_lsu;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_lsu_if bus();

    mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]  ref_mem [0:63];
    logic [31:0] bus_mem [0:15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] exp_decode(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 2'b11;
        if ((a % acc_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int sz;
        sz = acc_size(f3);
        v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(a + i) % 64];
        if (sz == 1) v = f3[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        if (sz == 2) v = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // delay < 0: memory never answers
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int delay,
                           input bit spur_idle, input bit spur_issue);
        logic [1:0]  derr, eerr;
        logic [31:0] erd, ewd;
        logic [3:0]  emask;
        int sz, elat, nstb;
        bit got;
        derr  = exp_decode(we, f3, a);
        sz    = acc_size(f3);
        eerr  = (derr == 2'b00 && delay < 0) ? 2'b10 : derr;
        erd   = (eerr == 2'b00 && !we) ? ref_load(f3, a) : 32'd0;
        elat  = (derr != 2'b00) ? 1 : ((delay < 0) ? TIMEOUT + 2 : 3 + delay);
        emask = 4'd0;
        if (we) for (int i = 0; i < sz; i++) emask[(a % 4) + i] = 1'b1;
        ewd   = (sz == 1) ? {4{wd[7:0]}} : ((sz == 2) ? {2{wd[15:0]}} : wd);
        nstb  = 0;
        got   = 1'b0;

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.mem_done   = spur_idle;
        bus.mem_rdata  = $urandom;
        check("req_ready_idle", bus.req_ready, 1);
        @(posedge clk);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            bus.req_valid  = 1'b0;
            bus.req_we     = 1'($urandom);
            bus.req_funct3 = 3'($urandom);
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            check("strobe_excl", bus.mem_wstrobe & bus.mem_rstrobe, 0);
            if (bus.mem_wstrobe || bus.mem_rstrobe) begin
                nstb++;
                check("strobe_dir", bus.mem_wstrobe, we);
                check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
                check("mem_wmask", bus.mem_wmask, emask);
                if (bus.mem_wstrobe) begin
                    check("mem_wdata", bus.mem_wdata, ewd);
                    for (int j = 0; j < 4; j++)
                        if (bus.mem_wmask[j]) bus_mem[bus.mem_addr[5:2]][8*j +: 8] = bus.mem_wdata[8*j +: 8];
                end else begin
                    bus.mem_rdata = bus_mem[bus.mem_addr[5:2]];
                end
            end
            if (k == 0) bus.mem_done = spur_issue;
            else        bus.mem_done = (delay >= 0) && (k - 1 >= delay);
            if (bus.resp_valid) begin
                got = 1'b1;
                check("latency", k + 1, elat);
                check("resp_err", bus.resp_err, eerr);
                check("resp_rdata", bus.resp_rdata, erd);
                check("ready_in_resp", bus.req_ready, 0);
            end
        end
        if (!got) check("resp_missing", 0, 1);
        check("strobe_count", nstb, (derr == 2'b00) ? 1 : 0);
        bus.mem_done = 1'b0;
        if (derr == 2'b00 && we)
            for (int i = 0; i < sz; i++) ref_mem[(a + i) % 64] = wd[8*i +: 8];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.resp_valid, 0);
        check({tag, "_rdata"}, bus.resp_rdata, 0);
        check({tag, "_err"},   bus.resp_err, 0);
        check({tag, "_addr"},  bus.mem_addr, 0);
        check({tag, "_wdata"}, bus.mem_wdata, 0);
        check({tag, "_wmask"}, bus.mem_wmask, 0);
        check({tag, "_strb"},  {bus.mem_wstrobe, bus.mem_rstrobe}, 0);
        check({tag, "_ready"}, bus.req_ready, 1);
    endtask

    // Reset lands while the store strobe is high
    task automatic reset_mid_issue(input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_pre_wstrobe", bus.mem_wstrobe, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_after");
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.mem_rdata  = 32'd0;
        bus.mem_done   = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
        for (int i = 0; i < 16; i++) bus_mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, 1'b0);
        run_req(1'b1, 3'b010, 32'h10, 32'h0, 1, 1'b0, 1'b0);
        run_req(1'b1, 3'b000, 32'h13, 32'h80, 0, 1'b0, 1'b0);
        run_req(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b0, 1'b0);
        run_req(1'b0, 3'b100, 32'h13, 32'h0, 2, 1'b0, 1'b0);
        run_req(1'b1, 3'b001, 32'h12, 32'h8001, 0, 1'b0, 1'b0);
        run_req(1'b0, 3'b001, 32'h12, 32'h0, 0, 1'b0, 1'b0);
        run_req(1'b0, 3'b101, 32'h12, 32'h0, 0, 1'b0, 1'b0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, 1'b0);
        run_req(1'b0, 3'b010, 32'h11, 32'h0, 0, 1'b1, 1'b1);
        run_req(1'b1, 3'b001, 32'h13, 32'h1234, 0, 1'b0, 1'b0);
        run_req(1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0, 1'b0);
        run_req(1'b1, 3'b100, 32'h10, 32'h0, 0, 1'b0, 1'b0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, -1, 1'b1, 1'b1);
        reset_mid_issue(32'h24, 32'hCAFEF00D);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            int dly;
            dly = (($urandom % 8) == 0) ? -1 : int'($urandom % 4);
            run_req(1'($urandom), 3'($urandom), 32'($urandom % 64), $urandom, dly,
                    1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit between the CPU execute stage and the word-addressed memory port (mem_addr / mem_wdata / mem_wmask / mem_wstrobe / mem_rstrobe / mem_rdata / mem_done). It accepts one RV32 load or store per handshake and checks alignment. It converts byte and halfword accesses into word accesses with byte masks, drives single-cycle strobes, and waits for mem_done. For loads it returns sign- or zero-extended data.

## Interface
- TIMEOUT, 16: cycles to wait for mem_done before a bus-fault response; must be ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  CPU request present.
- req_ready  out  1  high only in IDLE; accept when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3.
- mem_addr  out  32  word-aligned address; bits [1:0] are always 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_wmask  out  4  byte-lane enables.
- mem_wstrobe / mem_rstrobe  out  1  write / read strobe.
- mem_rdata  in  32  word read data; valid the cycle after the read strobe edge.
- mem_done  in  1  transaction complete. It may be high spuriously before the strobe edge, so it is ignored outside WAIT.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready = 1. On accept, latch we, funct3, addr, wdata, then decode:
  - Illegal funct3 → RESP with err 11. This covers funct3 011, 110, 111 for either direction, and 100 or 101 for stores.
  - Misaligned → RESP with err 01. Misaligned means: LH, LHU or SH with addr[0]=1; LW or SW with addr[1:0]≠0.
  - Otherwise → ISSUE.
- ISSUE (exactly one cycle):
  - Exactly one of mem_wstrobe or mem_rstrobe is high.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - mem_done = 1 → RESP. For loads, capture the extracted data from mem_rdata on this edge.
  - Counter reaches TIMEOUT-1 → RESP with err 10.
  - Otherwise increment the counter.
- RESP: resp_valid = 1 for one cycle, then IDLE.
- Address, mask and write data stay registered and constant from ISSUE through RESP. In IDLE these outputs keep their last values.
- Store lanes:
  - SB: mask = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: mask = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: mask = 1111.
- Loads: mem_wmask = 0000. Let sh = rdata >> (8·addr[1:0]).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: rdata unmodified.
- Errors: no memory strobe is ever driven for misaligned or illegal requests.
- Reset while rst is high:
  - State goes to IDLE and the counter to 0.
  - Outputs: resp_valid = 0, resp_rdata = 0, resp_err = 00, mem_addr = 0, mem_wdata = 0, mem_wmask = 0, both strobes = 0, req_ready = 1.
  - Reset mid-ISSUE drops the strobe immediately. The write may or may not have committed, and no response is generated.

## Timing
- Accept at edge E0 → strobe high during cycle E0..E1 → WAIT during E1..E2.
  - mem_done high in WAIT → resp_valid during E2..E3.
  - Best-case latency: 3 cycles from accept to response; next accept possible at E3.
- Error response (misaligned or illegal): resp_valid during E0..E1; next accept at E1.
- Timeout: resp_valid asserts TIMEOUT+2 cycles after accept.
- Strobes are never high for more than one cycle per request.
- Strobes are never high outside ISSUE, and both are never high together.
- resp_valid and req_ready are never high in the same cycle.

## Test plan
- SW to 0x10 with wdata 0xDEADBEEF, then LW from 0x10:
  - Store: one wstrobe cycle with mask 1111.
  - Load: resp_rdata = 0xDEADBEEF, err 00, resp_valid 3 cycles after accept.
- Bytes: SB 0x80 to 0x13, then read from word 0x10 (which holds 0x00000000 before the SB):
  - SB drives mask 1000 and wdata 0x80808080.
  - LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080.
- Halfwords: SH 0x8001 to 0x12, then LH 0x12 → 0xFFFF8001 and LHU 0x12 → 0x00008001; the word at 0x10 reads back upper half 0x8001 with the lower half unchanged.
- Alignment and decode errors, each with no strobe asserted:
  - LW 0x11 and SH 0x13 → err 01, 1-cycle response.
  - funct3 011 → err 11.
- Timeout: hold mem_done low with TIMEOUT = 4.
  - err 10 and resp_rdata 0 at accept+6.
  - A spurious mem_done high during IDLE or ISSUE does not shorten latency.
- Reset: assert rst during ISSUE of an SW.
  - Strobe drops in the same cycle and all outputs reach their reset values.
  - After release, a new LW completes normally with no stale response.
